// File: rtl/crypt_run_if.sv
// Host/core handshake bundle for crypt_run_controller.
// master = host register block plus crypto core side, slave = controller.
`default_nettype none

interface crypt_run_if #(
  parameter int TEXT_BITS = 128,
  parameter int KEY_BITS  = 128,
  parameter int CNT_W     = 8
);
  logic                 go_i;
  logic                 abort_i;
  logic [CNT_W-1:0]     repeat_i;
  logic [KEY_BITS-1:0]  key_i;
  logic [TEXT_BITS-1:0] text_i;
  logic                 core_load_o;
  logic                 core_start_o;
  logic [KEY_BITS-1:0]  core_key_o;
  logic [TEXT_BITS-1:0] core_text_o;
  logic                 core_done_i;
  logic [TEXT_BITS-1:0] core_result_i;
  logic [TEXT_BITS-1:0] result_o;
  logic [7:0]           status_o;
  logic                 trigger_o;
  logic [CNT_W-1:0]     runs_done_o;

  modport master (
    output go_i, abort_i, repeat_i, key_i, text_i, core_done_i, core_result_i,
    input  core_load_o, core_start_o, core_key_o, core_text_o,
           result_o, status_o, trigger_o, runs_done_o
  );

  modport slave (
    input  go_i, abort_i, repeat_i, key_i, text_i, core_done_i, core_result_i,
    output core_load_o, core_start_o, core_key_o, core_text_o,
           result_o, status_o, trigger_o, runs_done_o
  );
endinterface

`default_nettype wire

// File: rtl/crypt_run_controller.sv
// Sequences repeated load/start/wait/capture runs of the crypto core from host-latched key/text,
// with timeout, abort, result capture and a scope trigger covering each run.
`default_nettype none

module crypt_run_controller #(
  parameter int TEXT_BITS      = 128,
  parameter int KEY_BITS       = 128,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 4
) (
  input  wire         clk,
  input  wire         rst_n,
  crypt_run_if.slave  bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]           state;
  logic [KEY_BITS-1:0]  key_lat;
  logic [TEXT_BITS-1:0] text_lat;
  logic [TEXT_BITS-1:0] result;
  logic [CNT_W-1:0]     runs_total;
  logic [CNT_W-1:0]     runs_done;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic                 aborted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      key_lat    <= '0;
      text_lat   <= '0;
      result     <= '0;
      runs_total <= '0;
      runs_done  <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      aborted    <= 1'b0;
    end else if (bus.abort_i && (state != ST_IDLE)) begin
      // Abort outranks a same-cycle done: the in-flight result is dropped.
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      aborted <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.go_i) begin
            key_lat    <= bus.key_i;
            text_lat   <= bus.text_i;
            runs_total <= (bus.repeat_i == '0) ? CNT_W'(1) : bus.repeat_i;
            runs_done  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            timeout    <= 1'b0;
            aborted    <= 1'b0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_START;
        ST_START: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.core_done_i) begin
            result <= bus.core_result_i;
            if (runs_done != '1) begin
              runs_done <= runs_done + 1'b1;
            end
            state <= ST_CAPTURE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (runs_done >= runs_total) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FINISH;
          end else begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.core_load_o  = (state == ST_LOAD);
  assign bus.core_start_o = (state == ST_START);
  assign bus.trigger_o    = (state == ST_START) || (state == ST_WAIT) || (state == ST_CAPTURE);
  assign bus.core_key_o   = key_lat;
  assign bus.core_text_o  = text_lat;
  assign bus.result_o     = result;
  assign bus.runs_done_o  = runs_done;
  assign bus.status_o     = {4'b0000, aborted, timeout, done, busy};

endmodule

`default_nettype wire
